// File: rtl/frame_pick_pkg.sv
// Shared definitions for the frame_pick block.
//   state_e        : FSM state encoding used by frame_pick and frame_pick_sync
//   SYNC_A_DEF     : default first/second header word
//   SYNC_B_DEF     : default third header word
package frame_pick_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HUNT0 = 3'd1,
    ST_HUNT1 = 3'd2,
    ST_HUNT2 = 3'd3,
    ST_CTRL  = 3'd4,
    ST_DATA  = 3'd5
  } state_e;

  localparam logic [15:0] SYNC_A_DEF = 16'hFFFF;
  localparam logic [15:0] SYNC_B_DEF = 16'hAAAA;

endpackage

// File: rtl/frame_pick_sync.sv
// Header detector for frame_pick: walks SYNC_A, SYNC_A, SYNC_B on the
// qualified word stream while hunt_en is high.
//   clk, rst    : clock, synchronous active-high reset
//   hunt_en     : parent is hunting; position is held at HUNT0 while low
//   din_valid   : qualifies din; position only moves on valid words
//   din         : raw word stream
//   hdr_found   : one-cycle strobe, high on the cycle SYNC_B completes a header
//   hunt_state  : current hunt position (ST_HUNT0..ST_HUNT2)
module frame_pick_sync
  import frame_pick_pkg::*;
#(
  parameter int                 PIXEL_W = 16,
  parameter logic [PIXEL_W-1:0] SYNC_A  = PIXEL_W'(SYNC_A_DEF),
  parameter logic [PIXEL_W-1:0] SYNC_B  = PIXEL_W'(SYNC_B_DEF)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               hunt_en,
  input  logic               din_valid,
  input  logic [PIXEL_W-1:0] din,
  output logic               hdr_found,
  output state_e             hunt_state
);

  state_e hunt_q, hunt_d;

  always_comb begin
    hunt_d    = hunt_q;
    hdr_found = 1'b0;
    if (!hunt_en) begin
      // Parked at the start so every new hunt begins from scratch.
      hunt_d = ST_HUNT0;
    end else if (din_valid) begin
      case (hunt_q)
        ST_HUNT0: if (din == SYNC_A) hunt_d = ST_HUNT1;
        ST_HUNT1: hunt_d = (din == SYNC_A) ? ST_HUNT2 : ST_HUNT0;
        ST_HUNT2: begin
          if (din == SYNC_B) begin
            hdr_found = 1'b1;
            hunt_d    = ST_HUNT0;
          end else if (din == SYNC_A) begin
            // A longer run of SYNC_A still ends in a valid header.
            hunt_d = ST_HUNT2;
          end else begin
            hunt_d = ST_HUNT0;
          end
        end
        default: hunt_d = ST_HUNT0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) hunt_q <= ST_HUNT0;
    else     hunt_q <= hunt_d;
  end

  assign hunt_state = hunt_q;

endmodule

// File: rtl/frame_pick.sv
// Frame extractor: after GO (or continuously with CONT) finds a
// SYNC_A SYNC_A SYNC_B header, takes the next word as control word, uses its
// low CNT_W bits as pixel count N and forwards the following N valid words as
// pixels, flagging the last one.
//   CLK, RST     : clock, synchronous active-high reset
//   GO           : arm capture of one frame from IDLE
//   CONT         : re-arm automatically after each frame
//   DIN_VALID    : qualifies DIN
//   DIN          : raw word stream
//   PIXEL_VALID  : registered pixel strobe
//   PIXEL_DATA   : registered pixel, zero when PIXEL_VALID is low
//   PIXEL_LAST   : registered, high with the last pixel of a frame
//   FRAME_CTRL   : control word of the current/last accepted frame
//   BUSY         : high in every state except IDLE
//   ERR_LEN      : one-cycle pulse when the pixel count is 0 or too large
module frame_pick
  import frame_pick_pkg::*;
#(
  parameter int                 PIXEL_W    = 16,
  parameter int                 MAX_PIXELS = 1024,
  parameter logic [PIXEL_W-1:0] SYNC_A     = PIXEL_W'(SYNC_A_DEF),
  parameter logic [PIXEL_W-1:0] SYNC_B     = PIXEL_W'(SYNC_B_DEF)
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               GO,
  input  logic               CONT,
  input  logic               DIN_VALID,
  input  logic [PIXEL_W-1:0] DIN,
  output logic               PIXEL_VALID,
  output logic [PIXEL_W-1:0] PIXEL_DATA,
  output logic               PIXEL_LAST,
  output logic [PIXEL_W-1:0] FRAME_CTRL,
  output logic               BUSY,
  output logic               ERR_LEN
);

  localparam int CNT_W = $clog2(MAX_PIXELS + 1);

  // main_q only uses ST_HUNT0 to mean "hunting"; the finer hunt position
  // lives in the sync sub-module.
  state_e               main_q, main_d;
  state_e               hunt_state;
  state_e               state;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [PIXEL_W-1:0]   ctrl_q, ctrl_d;
  logic                 pv_q, pv_d;
  logic [PIXEL_W-1:0]   pd_q, pd_d;
  logic                 pl_q, pl_d;
  logic                 err_q, err_d;
  logic                 hdr_found;
  logic [CNT_W-1:0]     n_w;
  logic                 len_ok;

  frame_pick_sync #(
    .PIXEL_W (PIXEL_W),
    .SYNC_A  (SYNC_A),
    .SYNC_B  (SYNC_B)
  ) u_sync (
    .clk        (CLK),
    .rst        (RST),
    .hunt_en    (main_q == ST_HUNT0),
    .din_valid  (DIN_VALID),
    .din        (DIN),
    .hdr_found  (hdr_found),
    .hunt_state (hunt_state)
  );

  assign state = (main_q == ST_HUNT0) ? hunt_state : main_q;

  // Pixel count is the low CNT_W bits of the control word; upper bits are
  // carried only in FRAME_CTRL.
  assign n_w    = CNT_W'(DIN);
  assign len_ok = (n_w != '0) && (n_w <= CNT_W'(MAX_PIXELS));

  always_comb begin
    main_d = main_q;
    cnt_d  = cnt_q;
    ctrl_d = ctrl_q;
    pv_d   = 1'b0;
    pd_d   = '0;
    pl_d   = 1'b0;
    err_d  = 1'b0;
    case (main_q)
      ST_IDLE: begin
        if (GO) main_d = ST_HUNT0;
      end
      ST_HUNT0: begin
        if (hdr_found) main_d = ST_CTRL;
      end
      ST_CTRL: begin
        if (DIN_VALID) begin
          ctrl_d = DIN;
          if (len_ok) begin
            cnt_d  = n_w;
            main_d = ST_DATA;
          end else begin
            err_d  = 1'b1;
            main_d = ST_HUNT0;
          end
        end
      end
      ST_DATA: begin
        if (DIN_VALID) begin
          pv_d  = 1'b1;
          pd_d  = DIN;
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            pl_d   = 1'b1;
            main_d = CONT ? ST_HUNT0 : ST_IDLE;
          end
        end
      end
      default: main_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      main_q <= ST_IDLE;
      cnt_q  <= '0;
      ctrl_q <= '0;
      pv_q   <= 1'b0;
      pd_q   <= '0;
      pl_q   <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      main_q <= main_d;
      cnt_q  <= cnt_d;
      ctrl_q <= ctrl_d;
      pv_q   <= pv_d;
      pd_q   <= pd_d;
      pl_q   <= pl_d;
      err_q  <= err_d;
    end
  end

  assign PIXEL_VALID = pv_q;
  assign PIXEL_DATA  = pd_q;
  assign PIXEL_LAST  = pl_q;
  assign FRAME_CTRL  = ctrl_q;
  assign BUSY        = (state != ST_IDLE);
  assign ERR_LEN     = err_q;

endmodule

// File: tb/tb_frame_pick.sv
module tb_frame_pick;

  localparam int          PIXEL_W    = 16;
  localparam int          MAX_PIXELS = 1024;
  localparam int          CNT_W      = $clog2(MAX_PIXELS + 1);
  localparam logic [15:0] SA         = 16'hFFFF;
  localparam logic [15:0] SB         = 16'hAAAA;

  logic        CLK = 1'b0;
  logic        RST, GO, CONT, DIN_VALID;
  logic [15:0] DIN;
  logic        PIXEL_VALID, PIXEL_LAST, BUSY, ERR_LEN;
  logic [15:0] PIXEL_DATA, FRAME_CTRL;

  int n_checks = 0;
  int n_fail   = 0;
  int err_seen = 0;
  int err_exp  = 0;
  bit mon_en   = 1'b0;
  logic err_prev = 1'b0;

  // Expected pixel stream: {last, data}, filled from the payload the bench builds.
  logic [16:0] exp_q[$];
  logic [15:0] pay_q[$];
  logic [16:0] mon_e;

  logic [15:0] nz, ctrl;
  logic [4:0]  upper;
  int          n, r;
  bit          armed;
  bit          bad;

  always #5 CLK = ~CLK;

  frame_pick #(
    .PIXEL_W    (PIXEL_W),
    .MAX_PIXELS (MAX_PIXELS),
    .SYNC_A     (16'hFFFF),
    .SYNC_B     (16'hAAAA)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .GO          (GO),
    .CONT        (CONT),
    .DIN_VALID   (DIN_VALID),
    .DIN         (DIN),
    .PIXEL_VALID (PIXEL_VALID),
    .PIXEL_DATA  (PIXEL_DATA),
    .PIXEL_LAST  (PIXEL_LAST),
    .FRAME_CTRL  (FRAME_CTRL),
    .BUSY        (BUSY),
    .ERR_LEN     (ERR_LEN)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Output monitor on the falling edge.
  always @(negedge CLK) begin
    if (mon_en) begin
      if (PIXEL_VALID) begin
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          check("pixel", {15'd0, PIXEL_LAST, PIXEL_DATA}, {15'd0, mon_e});
        end else begin
          check("pixel_unexpected", {15'd0, PIXEL_LAST, PIXEL_DATA}, 32'hFFFF_FFFF);
        end
      end else begin
        check("data_zero_when_invalid", {16'd0, PIXEL_DATA}, 32'd0);
        check("last_without_valid", {31'd0, PIXEL_LAST}, 32'd0);
      end
      if (ERR_LEN) begin
        err_seen++;
        check("err_pulse_width", {31'd0, err_prev}, 32'd0);
      end
      err_prev = ERR_LEN;
    end
  end

  task automatic step(input logic v, input logic [15:0] d);
    DIN_VALID = v;
    DIN       = d;
    @(posedge CLK);
    #1;
  endtask

  task automatic vword(input logic [15:0] d, input int gap);
    int k;
    k = (gap == 1) ? 1 : ((gap == 2) ? int'($urandom_range(0, 2)) : 0);
    repeat (k) step(1'b0, 16'($urandom));
    step(1'b1, d);
  endtask

  task automatic go_pulse();
    GO = 1'b1;
    step(1'b0, 16'h0);
    GO = 1'b0;
  endtask

  // Sends header + control word (+ payload when the count is legal) and
  // records what the block must produce for it.
  task automatic send_frame(input logic [15:0] c, input int gap);
    int nn;
    nn = int'(c) % (1 << CNT_W);
    vword(SA, gap);
    vword(SA, gap);
    vword(SB, gap);
    vword(c, gap);
    if (nn == 0 || nn > MAX_PIXELS) begin
      err_exp++;
    end else begin
      for (int i = 0; i < nn; i++) begin
        exp_q.push_back({(i == nn - 1), pay_q[i]});
        vword(pay_q[i], gap);
      end
    end
  endtask

  task automatic fill_random(input int cnt);
    int rr;
    pay_q.delete();
    for (int i = 0; i < cnt; i++) begin
      rr = int'($urandom_range(0, 3));
      if (rr == 0)      pay_q.push_back(SA);
      else if (rr == 1) pay_q.push_back(SB);
      else              pay_q.push_back(16'($urandom));
    end
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) step(1'b0, 16'($urandom));
  endtask

  initial begin
    // Reset, with GO and valid sync data present to show reset priority.
    RST = 1'b1; GO = 1'b1; CONT = 1'b0; DIN_VALID = 1'b1; DIN = SA;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    check("rst_pixel_valid", {31'd0, PIXEL_VALID}, 32'd0);
    check("rst_pixel_data", {16'd0, PIXEL_DATA}, 32'd0);
    check("rst_pixel_last", {31'd0, PIXEL_LAST}, 32'd0);
    check("rst_frame_ctrl", {16'd0, FRAME_CTRL}, 32'd0);
    check("rst_busy", {31'd0, BUSY}, 32'd0);
    check("rst_err_len", {31'd0, ERR_LEN}, 32'd0);
    GO = 1'b0; DIN_VALID = 1'b0;
    RST = 1'b0;
    mon_en = 1'b1;
    idle(2);
    check("idle_no_go_busy", {31'd0, BUSY}, 32'd0);

    // Basic 4-pixel frame with per-cycle latency checks.
    go_pulse();
    check("go_busy", {31'd0, BUSY}, 32'd1);
    vword(SA, 0); vword(SA, 0); vword(SB, 0); vword(16'h0004, 0);
    check("f1_ctrl", {16'd0, FRAME_CTRL}, 32'h0004);
    check("f1_hdr_no_pixel", {31'd0, PIXEL_VALID}, 32'd0);
    pay_q = '{16'h0011, 16'h0022, 16'h0033, 16'h0044};
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back({(i == 3), pay_q[i]});
      vword(pay_q[i], 0);
      check("f1_valid_latency", {31'd0, PIXEL_VALID}, 32'd1);
      check("f1_data_latency", {16'd0, PIXEL_DATA}, {16'd0, pay_q[i]});
    end
    check("f1_busy_after", {31'd0, BUSY}, 32'd0);
    idle(1);
    check("f1_valid_one_cycle", {31'd0, PIXEL_VALID}, 32'd0);

    // Same frame with a dead cycle before every word.
    go_pulse();
    send_frame(16'h0004, 1);
    idle(3);
    check("f2_drain", exp_q.size(), 32'd0);
    check("f2_busy_after", {31'd0, BUSY}, 32'd0);
    check("f2_ctrl", {16'd0, FRAME_CTRL}, 32'h0004);

    // Overlapping sync run, single-pixel frame.
    go_pulse();
    vword(SA, 0);
    exp_q.push_back({1'b1, 16'h5A5A});
    send_frame_prefixless: begin
      pay_q = '{16'h5A5A};
      send_frame(16'h0001, 0);
    end
    check("f3_busy_after", {31'd0, BUSY}, 32'd0);
    check("f3_ctrl", {16'd0, FRAME_CTRL}, 32'h0001);
    // send_frame queued the pixel too; drop the duplicate queued above.
    void'(exp_q.pop_back());

    // Broken header start is discarded; sync words inside payload are pixels.
    go_pulse();
    vword(SA, 0); vword(16'h1234, 0);
    pay_q = '{16'hBEEF, SA};
    send_frame(16'h0002, 0);
    idle(2);
    check("f4_drain", exp_q.size(), 32'd0);
    check("f4_busy_after", {31'd0, BUSY}, 32'd0);

    // Illegal counts: zero and MAX_PIXELS+1, then a good frame without GO.
    go_pulse();
    send_frame(16'h0000, 0);
    check("err0_pulse", {31'd0, ERR_LEN}, 32'd1);
    check("err0_busy", {31'd0, BUSY}, 32'd1);
    idle(1);
    check("err0_pulse_end", {31'd0, ERR_LEN}, 32'd0);
    send_frame(16'(MAX_PIXELS + 1), 0);
    check("errmax_pulse", {31'd0, ERR_LEN}, 32'd1);
    check("errmax_ctrl", {16'd0, FRAME_CTRL}, 32'(MAX_PIXELS + 1));
    pay_q = '{16'h0101, SB, 16'h0303};
    send_frame(16'h0003, 0);
    idle(2);
    check("err_count", err_seen, 32'(err_exp));
    check("err_then_good_drain", exp_q.size(), 32'd0);

    // Continuous mode, two back-to-back N=2 frames, then a last one with CONT low.
    CONT = 1'b1;
    go_pulse();
    pay_q = '{16'hC001, 16'hC002};
    send_frame(16'h0002, 0);
    check("cont_busy1", {31'd0, BUSY}, 32'd1);
    pay_q = '{16'hC003, 16'hC004};
    send_frame(16'h0002, 0);
    check("cont_busy2", {31'd0, BUSY}, 32'd1);
    CONT = 1'b0;
    pay_q = '{16'hC005};
    send_frame(16'h0001, 0);
    check("cont_off_idle", {31'd0, BUSY}, 32'd0);

    // Reset mid-frame after two of four pixels.
    go_pulse();
    vword(SA, 0); vword(SA, 0); vword(SB, 0); vword(16'h0004, 0);
    exp_q.push_back({1'b0, 16'hD001});
    vword(16'hD001, 0);
    exp_q.push_back({1'b0, 16'hD002});
    vword(16'hD002, 0);
    RST = 1'b1;
    step(1'b1, 16'hD003);
    RST = 1'b0;
    check("midrst_valid", {31'd0, PIXEL_VALID}, 32'd0);
    check("midrst_data", {16'd0, PIXEL_DATA}, 32'd0);
    check("midrst_ctrl", {16'd0, FRAME_CTRL}, 32'd0);
    check("midrst_busy", {31'd0, BUSY}, 32'd0);
    vword(16'hD004, 0);
    vword(SA, 0); vword(SA, 0); vword(SB, 0); vword(16'h0001, 0); vword(16'h7777, 0);
    check("midrst_not_resumed", {31'd0, BUSY}, 32'd0);
    go_pulse();
    pay_q = '{16'hE001, 16'hE002, 16'hE003, 16'hE004};
    send_frame(16'h0004, 0);
    check("postrst_busy", {31'd0, BUSY}, 32'd0);
    idle(2);
    check("postrst_drain", exp_q.size(), 32'd0);

    // Randomized frames against the payload/count model.
    armed = 1'b0;
    for (int k = 0; k < 25; k++) begin
      CONT = 1'($urandom_range(0, 1));
      if (!armed) go_pulse();
      repeat ($urandom_range(0, 3)) begin
        nz = 16'($urandom);
        if (nz == SA) nz = 16'h1234;
        step(1'($urandom_range(0, 1)), nz);
      end
      bad   = ($urandom_range(0, 5) == 0);
      upper = 5'($urandom);
      if (bad) begin
        r    = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(MAX_PIXELS + 1, (1 << CNT_W) - 1));
        ctrl = {upper, 11'(r)};
        send_frame(ctrl, 2);
        check("rnd_bad_ctrl", {16'd0, FRAME_CTRL}, {16'd0, ctrl});
        armed = 1'b1;
      end else begin
        n    = (k == 3) ? MAX_PIXELS : int'($urandom_range(1, 8));
        ctrl = {upper, 11'(n)};
        fill_random(n);
        send_frame(ctrl, 2);
        check("rnd_ctrl", {16'd0, FRAME_CTRL}, {16'd0, ctrl});
        check("rnd_busy_after", {31'd0, BUSY}, {31'd0, CONT});
        armed = CONT;
      end
    end
    idle(4);
    check("rnd_drain", exp_q.size(), 32'd0);
    check("rnd_err_count", err_seen, 32'(err_exp));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/frame_pick.md
FRAME_PICK -- requirements
Module: frame_pick

Interface
REQ-001 SHALL have parameter PIXEL_W, default 16, pixel/data word width.
REQ-002 SHALL have parameter MAX_PIXELS, default 1024, largest legal pixel count per frame.
REQ-003 SHALL have parameter SYNC_A, default 16'hFFFF (zero-extended to PIXEL_W), first and second header word.
REQ-004 SHALL have parameter SYNC_B, default 16'hAAAA (zero-extended to PIXEL_W), third header word.
REQ-005 SHALL derive localparam CNT_W = $clog2(MAX_PIXELS+1).
REQ-006 SHALL have port CLK input 1: single clock; all logic on rising edge.
REQ-007 SHALL have port RST input 1: reset is synchronous and active-high.
REQ-008 SHALL have port GO input 1: arm capture of one frame from IDLE.
REQ-009 SHALL have port CONT input 1: continuous mode, re-arm after each frame without GO.
REQ-010 SHALL have port DIN_VALID input 1: DIN qualifier; FSM and counter advance only when high.
REQ-011 SHALL have port DIN input PIXEL_W: raw word stream.
REQ-012 SHALL have port PIXEL_VALID output 1: PIXEL_DATA holds a payload pixel.
REQ-013 SHALL have port PIXEL_DATA output PIXEL_W: payload pixel, zero when PIXEL_VALID low.
REQ-014 SHALL have port PIXEL_LAST output 1: high with the final pixel of a frame.
REQ-015 SHALL have port FRAME_CTRL output PIXEL_W: control word of the current/last accepted frame.
REQ-016 SHALL have port BUSY output 1: high in every state except IDLE.
REQ-017 SHALL have port ERR_LEN output 1: one-cycle pulse on illegal pixel count.

Function
REQ-018 SHALL implement states IDLE, HUNT0, HUNT1, HUNT2, CTRL, DATA; on cycles with DIN_VALID low, state, counter and FRAME_CTRL SHALL hold.
REQ-019 IDLE: GO=1 -> HUNT0 (GO not gated by DIN_VALID); GO ignored in all other states.
REQ-020 HUNT0: DIN==SYNC_A -> HUNT1, else stay.
REQ-021 HUNT1: DIN==SYNC_A -> HUNT2, else HUNT0.
REQ-022 HUNT2: DIN==SYNC_B -> CTRL; DIN==SYNC_A -> stay HUNT2 (overlapping sync runs accepted); else HUNT0.
REQ-023 CTRL: latch DIN into FRAME_CTRL; N = DIN[CNT_W-1:0]; N==0 or N>MAX_PIXELS -> ERR_LEN pulse next cycle, -> HUNT0; else load counter with N, -> DATA.
REQ-024 DATA: each valid word is a pixel; counter decrements per pixel; when counter==1, flag last and leave DATA.
REQ-025 After the last pixel: CONT=1 -> HUNT0, CONT=0 -> IDLE.
REQ-026 PIXEL_VALID, PIXEL_DATA, PIXEL_LAST SHALL be registered: a pixel accepted on cycle t appears on cycle t+1 for exactly one cycle.
REQ-027 Header and control words SHALL never appear on PIXEL_DATA; PIXEL_VALID high exactly N times per frame.
REQ-028 Sync words appearing inside DATA SHALL be treated as pixels (no resynchronisation mid-frame).
REQ-029 PIXEL_LAST SHALL only be high together with PIXEL_VALID; N==1 gives a single pixel with PIXEL_LAST high.

Reset
REQ-030 RST=1 SHALL, at the next CLK edge, force state IDLE, counter 0, PIXEL_VALID 0, PIXEL_DATA 0, PIXEL_LAST 0, FRAME_CTRL 0, BUSY 0, ERR_LEN 0.
REQ-031 RST SHALL take priority over GO, DIN_VALID and all transitions; a frame interrupted by RST SHALL be abandoned and not resumed.

Structure
REQ-032 State enum type and default SYNC_A/SYNC_B constants SHALL live in shared package frame_pick_pkg.
REQ-033 Header detection (HUNT0..HUNT2) SHALL be a sub-module frame_pick_sync, output a one-cycle "header found" strobe; counter, CTRL and DATA logic stay in frame_pick.

Verification
REQ-034 GO, stream FFFF FFFF AAAA 0004 11 22 33 44, DIN_VALID=1 -> PIXEL_VALID 4 cycles with 11,22,33,44, PIXEL_LAST on 44, FRAME_CTRL=0004, BUSY low after.
REQ-035 Same frame with DIN_VALID low every other cycle -> same 4 pixels, same order, gaps in PIXEL_VALID, no loss or duplication.
REQ-036 Stream FFFF FFFF FFFF AAAA 0001 5A5A -> frame accepted, single pixel 5A5A with PIXEL_LAST; FFFF 1234 FFFF FFFF AAAA ... -> first FFFF discarded, frame found.
REQ-037 Control word 0000 and (MAX_PIXELS+1) -> ERR_LEN one pulse each, no PIXEL_VALID, FSM back in HUNT0 and next good frame captured.
REQ-038 CONT=1, two back-to-back frames N=2 -> four pixels, two PIXEL_LAST pulses, BUSY stays high, no GO needed.
REQ-039 RST asserted after 2 of 4 pixels -> all outputs zero next cycle, state IDLE; new GO plus full frame captured correctly.
